user_input_debounce: RTL and testbench

Synchronizes and debounces a raw push-button level (e.g. an active-low DE1 KEY) before it reaches the high-to-low user-input edge detector. The block sits directly upstream of that detector and drives its `in` port. It guarantees a metastability-safe, glitch-free level that changes only after the raw input has held a new value for a programmable number of clock cycles.

---
 rtl/user_input_debounce.sv | 117 +++++++++++
 tb/tb_user_input_debounce.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_input_debounce.sv
// Two-flop synchronizer plus stability-qualified debounce for a raw push-button level.
// Optional abort counter output enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module user_input_debounce #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8,
  parameter logic        RESET_LEVEL   = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       in,
  output logic       out,
  output logic       pending
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_count
`endif
);

  typedef enum logic {StStable, StPending} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
  localparam bit               Bypass  = (STABLE_CYCLES == 1);

  state_e           state_q, state_d;
  logic             s1_q, s2_q;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_q <= RESET_LEVEL;
      s2_q <= RESET_LEVEL;
    end else begin
      s1_q <= in;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StStable;
      cnt_q   <= '0;
      out_q   <= RESET_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    abort   = 1'b0;
    unique case (state_q)
      StStable: begin
        cnt_d = '0;
        if (s2_q != out_q) begin
          // A one-cycle qualification window needs no PENDING visit.
          if (Bypass) begin
            out_d = s2_q;
          end else begin
            state_d = StPending;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      StPending: begin
        if (s2_q == out_q) begin
          abort   = 1'b1;
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          out_d   = s2_q;
          cnt_d   = '0;
          state_d = StStable;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StStable;
        cnt_d   = '0;
      end
    endcase
  end

  assign out     = out_q;
  assign pending = (state_q == StPending);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;

  always_comb begin
    glitch_d = glitch_q;
    if (abort && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_count = glitch_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_user_input_debounce.sv
// Scoreboard bench: expected out transitions are queued as stimulus is driven and
// matched against transitions captured by a monitor.
module tb_user_input_debounce;

  localparam int unsigned StableCycles = 4;

  typedef struct {
    logic        level;
    int unsigned edge_no;
  } ev_t;

  logic Clock;
  logic Reset;
  logic in_a, in_b;
  logic out_a, pending_a, out_b, pending_b;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_a, glitch_b;
`endif

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  logic last_out;

  user_input_debounce #(
    .STABLE_CYCLES(StableCycles),
    .CNT_W        (8),
    .RESET_LEVEL  (1'b1)
  ) u_dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .in     (in_a),
    .out    (out_a),
    .pending(pending_a)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_count(glitch_a)
`endif
  );

  user_input_debounce #(
    .STABLE_CYCLES(1),
    .CNT_W        (8),
    .RESET_LEVEL  (1'b1)
  ) u_dut_min (
    .Clock  (Clock),
    .Reset  (Reset),
    .in     (in_b),
    .out    (out_b),
    .pending(pending_b)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_count(glitch_b)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  // Record every change of out_a with the edge number that produced it.
  always @(negedge Clock) begin
    if (Reset) begin
      last_out = out_a;
    end else if (out_a !== last_out) begin
      obs_q.push_back('{level: out_a, edge_no: cyc});
      last_out = out_a;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clock);
      #1;
    end
  endtask

  task automatic wait_obs(input int budget);
    for (int i = 0; i < budget && obs_q.size() == 0; i++) tick(1);
  endtask

  task automatic test_reset();
    ev_t o, e;
    Reset = 1'b1;
    in_a  = 1'b0;
    in_b  = 1'b1;
    tick(2);
    checks++;
    if (out_a !== 1'b1) begin
      errors++; $display("FAIL reset_out: got %b want 1", out_a);
    end
    checks++;
    if (pending_a !== 1'b0) begin
      errors++; $display("FAIL reset_pending: got %b want 0", pending_a);
    end
    checks++;
    if (out_b !== 1'b1) begin
      errors++; $display("FAIL reset_out_min: got %b want 1", out_b);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (glitch_a !== 8'd0) begin
      errors++; $display("FAIL reset_glitch: got %0d want 0", glitch_a);
    end
`endif
    Reset = 1'b0;
    exp_q.push_back('{level: 1'b0, edge_no: cyc + StableCycles + 2});
    wait_obs(20);
    checks++;
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL reset_release: no out change, want out=%b at edge %0d", e.level, e.edge_no);
    end else begin
      o = obs_q.pop_front();
      if (o.level !== e.level || o.edge_no != e.edge_no) begin
        errors++;
        $display("FAIL reset_release: got out=%b at edge %0d want out=%b at edge %0d",
                 o.level, o.edge_no, e.level, e.edge_no);
      end
    end
  endtask

  task automatic test_clean_press();
    ev_t o, e;
    int n_pend;
    in_a = 1'b1;
    exp_q.push_back('{level: 1'b1, edge_no: cyc + StableCycles + 2});
    wait_obs(20);
    checks++;
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL idle_restore: no out change, want out=%b at edge %0d", e.level, e.edge_no);
    end else begin
      o = obs_q.pop_front();
      if (o.level !== e.level || o.edge_no != e.edge_no) begin
        errors++;
        $display("FAIL idle_restore: got out=%b at edge %0d want out=%b at edge %0d",
                 o.level, o.edge_no, e.level, e.edge_no);
      end
    end

    in_a = 1'b0;
    exp_q.push_back('{level: 1'b0, edge_no: cyc + StableCycles + 2});
    n_pend = 0;
    repeat (10) begin
      tick(1);
      if (pending_a === 1'b1) n_pend++;
    end
    checks++;
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL press: no out change, want out=%b at edge %0d", e.level, e.edge_no);
    end else begin
      o = obs_q.pop_front();
      if (o.level !== e.level || o.edge_no != e.edge_no) begin
        errors++;
        $display("FAIL press: got out=%b at edge %0d want out=%b at edge %0d",
                 o.level, o.edge_no, e.level, e.edge_no);
      end
    end
    checks++;
    if (n_pend != StableCycles - 1) begin
      errors++; $display("FAIL press_pending_len: got %0d cycles want %0d", n_pend, StableCycles - 1);
    end

    in_a = 1'b1;
    exp_q.push_back('{level: 1'b1, edge_no: cyc + StableCycles + 2});
    tick(10);
    checks++;
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL release: no out change, want out=%b at edge %0d", e.level, e.edge_no);
    end else begin
      o = obs_q.pop_front();
      if (o.level !== e.level || o.edge_no != e.edge_no) begin
        errors++;
        $display("FAIL release: got out=%b at edge %0d want out=%b at edge %0d",
                 o.level, o.edge_no, e.level, e.edge_no);
      end
    end
  endtask

  task automatic test_bounce();
    ev_t o, e;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] g0;
    g0 = glitch_a;
`endif
    for (int i = 0; i < 8; i++) begin
      in_a = i[0];
      tick(1);
    end
    in_a = 1'b0;
    exp_q.push_back('{level: 1'b0, edge_no: cyc + StableCycles + 2});
    wait_obs(20);
    checks++;
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL bounce_settle: no out change, want out=%b at edge %0d", e.level, e.edge_no);
    end else begin
      o = obs_q.pop_front();
      if (o.level !== e.level || o.edge_no != e.edge_no) begin
        errors++;
        $display("FAIL bounce_settle: got out=%b at edge %0d want out=%b at edge %0d",
                 o.level, o.edge_no, e.level, e.edge_no);
      end
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Each of the four one-cycle lows enters PENDING and aborts once.
    checks++;
    if (glitch_a !== g0 + 8'd4) begin
      errors++; $display("FAIL bounce_glitch: got %0d want %0d", glitch_a, g0 + 8'd4);
    end
`endif
  endtask

  task automatic test_short_pulse();
    ev_t o, e;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] g0;
`endif
    in_a = 1'b1;
    exp_q.push_back('{level: 1'b1, edge_no: cyc + StableCycles + 2});
    wait_obs(20);
    checks++;
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL pulse_idle: no out change, want out=%b at edge %0d", e.level, e.edge_no);
    end else begin
      o = obs_q.pop_front();
      if (o.level !== e.level || o.edge_no != e.edge_no) begin
        errors++;
        $display("FAIL pulse_idle: got out=%b at edge %0d want out=%b at edge %0d",
                 o.level, o.edge_no, e.level, e.edge_no);
      end
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    g0 = glitch_a;
`endif
    in_a = 1'b0;
    tick(3);
    in_a = 1'b1;
    tick(12);
    checks++;
    if (obs_q.size() != 0 || out_a !== 1'b1) begin
      errors++;
      $display("FAIL short_pulse: got %0d out changes, out=%b want 0 changes, out=1", obs_q.size(), out_a);
      obs_q.delete();
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (glitch_a !== g0 + 8'd1) begin
      errors++; $display("FAIL short_pulse_glitch: got %0d want %0d", glitch_a, g0 + 8'd1);
    end
`endif
  endtask

  task automatic test_reset_mid_pending();
    ev_t o, e;
    in_a = 1'b0;
    tick(4);
    checks++;
    if (pending_a !== 1'b1) begin
      errors++; $display("FAIL mid_pending_setup: got pending=%b want 1", pending_a);
    end
    Reset = 1'b1;
    tick(1);
    checks++;
    if (pending_a !== 1'b0 || out_a !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got pending=%b out=%b want pending=0 out=1", pending_a, out_a);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (glitch_a !== 8'd0) begin
      errors++; $display("FAIL mid_reset_glitch: got %0d want 0", glitch_a);
    end
`endif
    Reset = 1'b0;
    exp_q.push_back('{level: 1'b0, edge_no: cyc + StableCycles + 2});
    wait_obs(20);
    checks++;
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL reset_restart: no out change, want out=%b at edge %0d", e.level, e.edge_no);
    end else begin
      o = obs_q.pop_front();
      if (o.level !== e.level || o.edge_no != e.edge_no) begin
        errors++;
        $display("FAIL reset_restart: got out=%b at edge %0d want out=%b at edge %0d",
                 o.level, o.edge_no, e.level, e.edge_no);
      end
    end
  endtask

  task automatic test_min_qual();
    int unsigned start, first;
    int n_pend;
    start  = cyc;
    first  = 0;
    n_pend = 0;
    in_b   = 1'b0;
    repeat (6) begin
      tick(1);
      if (pending_b === 1'b1) n_pend++;
      if (out_b === 1'b0 && first == 0) first = cyc;
    end
    checks++;
    if (first != start + 3) begin
      errors++; $display("FAIL min_qual_edge: got out=0 at edge %0d want edge %0d", first, start + 3);
    end
    checks++;
    if (n_pend != 0) begin
      errors++; $display("FAIL min_qual_pending: got %0d pending cycles want 0", n_pend);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_pulse();
    test_reset_mid_pending();
    test_min_qual();
    tick(2);
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d unmatched changes, %0d unmet expectations want 0 and 0",
               obs_q.size(), exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
